async_fifo: RTL and testbench
=============================

ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, storage capacity in words, power of two, >= 8.
REQ-003 SHALL have parameter ADDR, default 7, pointer width = log2(DEPTH)+1, MSB used as wrap bit.
REQ-004 SHALL have port clka  input  1  sole clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rsta  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port ena  input  1  write-side enable.
REQ-007 SHALL have port wra  input  1  write strobe; qualified by ena.
REQ-008 SHALL have port dina  input  WIDTH  write data.
REQ-009 SHALL have port rstb  input  1  read-side synchronous active-high reset, sampled on clka, OR-ed with rsta.
REQ-010 SHALL have port enb  input  1  read request.
REQ-011 SHALL have port doutb  output  WIDTH  registered read data.
REQ-012 SHALL have port almost_full  output  1  occupancy >= DEPTH-2.
REQ-013 SHALL have port full  output  1  occupancy == DEPTH.
REQ-014 SHALL have port almost_empty  output  1  occupancy <= 2.
REQ-015 SHALL have port empty  output  1  occupancy == 0.

Function
REQ-016 SHALL accept a write on a clka edge when ena && wra && !full; dina is stored at the write pointer, which then increments modulo 2*DEPTH.
REQ-017 SHALL accept a read on a clka edge when enb && !empty; the word at the read pointer is loaded into doutb at that edge (1-cycle latency), and the read pointer increments.
REQ-018 SHALL hold doutb unchanged on every cycle without an accepted read.
REQ-019 SHALL ignore writes while full, including when a read is accepted in the same cycle; no data overwrite.
REQ-020 SHALL ignore reads while empty, including when a write is accepted in the same cycle; doutb holds.
REQ-021 SHALL keep occupancy unchanged when a write and a read are both accepted in one cycle.
REQ-022 SHALL derive occupancy as wr_ptr - rd_ptr in ADDR bits; full when low ADDR-1 bits equal and MSBs differ, empty when pointers are equal.
REQ-023 SHALL register all four flags, updated in the same edge as the pointer change they reflect (valid the cycle after the causing access).
REQ-024 SHALL preserve FIFO order across pointer wrap-around with no lost or duplicated words.
REQ-025 SHALL leave X-free data only; reading unwritten locations is impossible by construction.

Reset
REQ-026 SHALL, while rsta or rstb is high at a clka edge, clear both pointers, set doutb = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0.
REQ-027 SHALL discard all stored contents logically on reset mid-operation; accesses in a reset cycle are ignored.
REQ-028 SHALL not require memory array clearing on reset.

Structure
REQ-029 SHALL place default WIDTH/DEPTH constants and the almost-threshold margin (2) in a shared package fifo_pkg.
REQ-030 SHALL implement storage in one sub-module fifo_ram (single write port, single registered read port); pointer/flag logic stays in async_fifo.

Verification
REQ-031 SHALL verify reset: rsta=1 two cycles -> empty=1, almost_empty=1, full=0, almost_full=0, doutb=0.
REQ-032 SHALL verify fill: 64 writes 0x00..0x3F, no reads -> almost_full at count 62, full at 64, 65th write (0xAA) ignored.
REQ-033 SHALL verify drain: after fill, 64 reads -> doutb 0x00..0x3F in order one cycle after each request, empty after last, extra read holds 0x3F.
REQ-034 SHALL verify simultaneous: at count 10, write+read for 20 cycles -> count stays 10, order preserved.
REQ-035 SHALL verify wrap: stream 500 words writing only when !almost_full, reading when !almost_empty -> all 500 read in order.
REQ-036 SHALL verify mid-operation reset: count 30, assert rstb one cycle -> empty=1, next write then read returns that word.

Source files
------------

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the single-clock FIFO (async_fifo).
//   DEF_WIDTH     : default data word width in bits
//   DEF_DEPTH     : default storage capacity in words (power of two, >= 8)
//   DEF_ADDR      : default pointer width, log2(DEPTH)+1 (MSB is the wrap bit)
//   ALMOST_MARGIN : distance from full/empty at which the almost flags assert
//   fifo_flags_t  : bundle of the four registered status flags
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 64;
    localparam int DEF_ADDR      = $clog2(DEF_DEPTH) + 1;
    localparam int ALMOST_MARGIN = 2;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_ram.sv
// ----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage: one synchronous write port, one registered read
// port, both on clka.
// Ports:
//   clka  : clock
//   rst   : synchronous active-high reset, clears the read register only
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata loads mem[raddr] on the same edge
//   raddr : read address
//   rdata : registered read data, holds when re is low
// ----------------------------------------------------------------------------
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto plain RAM; stale contents
    // are never visible because the pointers are cleared instead.
    always_ff @(posedge clka) begin
        if (we) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs as they were before the edge.
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/async_fifo.sv
// ----------------------------------------------------------------------------
// async_fifo
// Single-clock FIFO with registered read data and registered status flags.
// Despite the name, write and read sides share the one clock clka.
// Ports:
//   clka         : clock, all logic on its rising edge
//   rsta         : synchronous active-high reset
//   ena, wra     : write accepted when ena && wra && !full
//   dina         : write data
//   rstb         : read-side synchronous active-high reset, OR-ed with rsta
//   enb          : read accepted when enb && !empty
//   doutb        : read data, valid the cycle after an accepted read, else holds
//   almost_full  : occupancy >= DEPTH-2
//   full         : occupancy == DEPTH
//   almost_empty : occupancy <= 2
//   empty        : occupancy == 0
// ----------------------------------------------------------------------------
module async_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR  = DEF_ADDR
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             ena,
    input  logic             wra,
    input  logic [WIDTH-1:0] dina,
    input  logic             rstb,
    input  logic             enb,
    output logic [WIDTH-1:0] doutb,
    output logic             almost_full,
    output logic             full,
    output logic             almost_empty,
    output logic             empty
);

    localparam int AW = ADDR - 1;

    logic            rst;
    logic            wr_acc;
    logic            rd_acc;
    logic [ADDR-1:0] wr_ptr;
    logic [ADDR-1:0] rd_ptr;
    logic [ADDR-1:0] wr_ptr_nxt;
    logic [ADDR-1:0] rd_ptr_nxt;
    logic [ADDR-1:0] occ_nxt;
    fifo_flags_t     flags;
    fifo_flags_t     flags_nxt;

    assign rst = rsta | rstb;

    // Acceptance is judged on the registered flags, so a full FIFO refuses a
    // write even when a read frees a slot in the same cycle (and vice versa).
    assign wr_acc = ena & wra & ~flags.full  & ~rst;
    assign rd_acc = enb       & ~flags.empty & ~rst;

    // Flags are computed from the post-edge pointers so they land on the same
    // edge as the pointer update they describe.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        flags_nxt  = '0;
        wr_ptr_nxt = wr_ptr + ADDR'(wr_acc);
        rd_ptr_nxt = rd_ptr + ADDR'(rd_acc);
        occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;

        flags_nxt.empty        = (wr_ptr_nxt == rd_ptr_nxt);
        flags_nxt.full         = (wr_ptr_nxt[ADDR-2:0] == rd_ptr_nxt[ADDR-2:0]) &&
                                 (wr_ptr_nxt[ADDR-1]   != rd_ptr_nxt[ADDR-1]);
        flags_nxt.almost_full  = (occ_nxt >= ADDR'(DEPTH - ALMOST_MARGIN));
        flags_nxt.almost_empty = (occ_nxt <= ADDR'(ALMOST_MARGIN));
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            flags.full         <= 1'b0;
            flags.almost_full  <= 1'b0;
            flags.empty        <= 1'b1;
            flags.almost_empty <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            flags  <= flags_nxt;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clka  (clka),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (dina),
        .re    (rd_acc),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (doutb)
    );

    assign full         = flags.full;
    assign almost_full  = flags.almost_full;
    assign empty        = flags.empty;
    assign almost_empty = flags.almost_empty;

endmodule

// File: tb/tb_async_fifo.sv
// ----------------------------------------------------------------------------
// tb_async_fifo
// Self-checking bench for async_fifo. A queue-based reference model tracks
// contents, read data and occupancy; every clock step compares the DUT's
// outputs against it, plus directed checks at the interesting boundaries.
// ----------------------------------------------------------------------------
module tb_async_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int ADDR  = 7;

    logic             clka = 1'b0;
    logic             rsta = 1'b0;
    logic             ena  = 1'b0;
    logic             wra  = 1'b0;
    logic [WIDTH-1:0] dina = '0;
    logic             rstb = 1'b0;
    logic             enb  = 1'b0;
    logic [WIDTH-1:0] doutb;
    logic             almost_full;
    logic             full;
    logic             almost_empty;
    logic             empty;

    always #5 clka = ~clka;

    async_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) dut (
        .clka         (clka),
        .rsta         (rsta),
        .ena          (ena),
        .wra          (wra),
        .dina         (dina),
        .rstb         (rstb),
        .enb          (enb),
        .doutb        (doutb),
        .almost_full  (almost_full),
        .full         (full),
        .almost_empty (almost_empty),
        .empty        (empty)
    );

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout = '0;
    int               rd_count = 0;
    bit               last_wr  = 1'b0;

    int    tests = 0;
    int    fails = 0;
    string phase = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s: observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = mq.size();
        check("doutb",        32'(doutb),        32'(m_dout));
        check("empty",        32'(empty),        32'(n == 0));
        check("full",         32'(full),         32'(n == DEPTH));
        check("almost_full",  32'(almost_full),  32'(n >= DEPTH - 2));
        check("almost_empty", 32'(almost_empty), 32'(n <= 2));
    endtask

    // One clock cycle: drive on the falling edge, advance the model at the
    // rising edge, compare 1 ns later.
    task automatic step(input logic r_a, input logic r_b, input logic e_a,
                        input logic w_a, input logic [WIDTH-1:0] d, input logic e_b);
        bit do_wr;
        bit do_rd;
        @(negedge clka);
        rsta = r_a;
        rstb = r_b;
        ena  = e_a;
        wra  = w_a;
        dina = d;
        enb  = e_b;
        @(posedge clka);
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        if (r_a || r_b) begin
            mq.delete();
            m_dout = '0;
        end else begin
            do_wr = e_a && w_a && (mq.size() != DEPTH);
            do_rd = e_b && (mq.size() != 0);
            if (do_rd) begin
                m_dout = mq.pop_front();
                rd_count++;
            end
            if (do_wr) mq.push_back(d);
        end
        last_wr = do_wr;
        #1;
        check_state();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        step(1'b0, 1'b0, 1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        int wr_n;
        int cyc;
        bit we;
        bit re;

        // Reset: rsta high for two cycles
        phase = "reset";
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("rst_empty",        32'(empty),        32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_full",         32'(full),         32'd0);
        check("rst_almost_full",  32'(almost_full),  32'd0);
        check("rst_doutb",        32'(doutb),        32'd0);
        idle();

        // Fill 0x00..0x3F with no reads
        phase = "fill";
        for (int i = 0; i < DEPTH; i++) begin
            wr(WIDTH'(i));
            if (i == 60) check("af_at_61", 32'(almost_full), 32'd0);
            if (i == 61) check("af_at_62", 32'(almost_full), 32'd1);
            if (i == 62) check("full_at_63", 32'(full), 32'd0);
        end
        check("full_at_64", 32'(full), 32'd1);
        wr(8'hAA);
        check("overflow_ignored", 32'(last_wr), 32'd0);
        check("still_full", 32'(full), 32'd1);

        // Drain: data comes back in order, one cycle after each request
        phase = "drain";
        for (int i = 0; i < DEPTH; i++) begin
            rd();
            check("drain_data", 32'(doutb), 32'(i));
        end
        check("empty_after_drain", 32'(empty), 32'd1);
        rd();
        check("underflow_holds", 32'(doutb), 32'h3F);
        idle();

        // Simultaneous write+read at occupancy 10
        phase = "simul";
        for (int i = 0; i < 10; i++) wr(WIDTH'($urandom));
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, WIDTH'($urandom), 1'b1);
        check("simul_not_empty", 32'(almost_empty), 32'd0);
        for (int i = 0; i < 10; i++) rd();
        check("simul_drained", 32'(empty), 32'd1);

        // Randomized streaming across several pointer wraps
        phase = "wrap";
        rd_count = 0;
        wr_n     = 0;
        cyc      = 0;
        while ((wr_n < 500 || mq.size() != 0) && cyc < 5000) begin
            we = (wr_n < 500) && !almost_full && ($urandom_range(0, 3) != 0);
            if (wr_n < 500) re = !almost_empty && ($urandom_range(0, 2) != 0);
            else            re = 1'b1;
            step(1'b0, 1'b0, we, we, WIDTH'($urandom), re);
            if (last_wr) wr_n++;
            cyc++;
        end
        check("wrap_written", 32'(wr_n), 32'd500);
        check("wrap_read", 32'(rd_count), 32'd500);
        check("wrap_empty", 32'(empty), 32'd1);

        // Mid-operation reset via rstb; the write offered in that cycle is lost
        phase = "midrst";
        for (int i = 0; i < 30; i++) wr(WIDTH'(8'h80 + i));
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
        check("rstb_empty",        32'(empty),        32'd1);
        check("rstb_almost_empty", 32'(almost_empty), 32'd1);
        check("rstb_doutb",        32'(doutb),        32'd0);
        wr(8'h5C);
        rd();
        check("post_rst_data", 32'(doutb), 32'h5C);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
